// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher feeding a small FIFO
// that presents the head instruction and its address to decode.
module fetch_unit #(
  parameter int DEPTH = 2
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic [15:0] I_pc,
  input  logic        I_flush,
  output logic        o_imem_req,
  output logic [15:0] o_imem_addr,
  input  logic        I_imem_ack,
  input  logic [15:0] I_imem_data,
  output logic        o_pc_adv,
  output logic        o_valid,
  output logic [15:0] o_instr,
  output logic [15:0] o_instr_pc,
  input  logic        I_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } state_t;

  state_t        state;
  logic [15:0]   fifo_instr [DEPTH];
  logic [15:0]   fifo_pc    [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // Flush overrides both push and pop so the buffer is simply emptied.
  always_comb begin
    push = (state == WAIT) && I_imem_ack && !I_flush;
    pop  = o_valid && I_ready && !I_flush;
  end

  always_comb begin
    o_valid    = (count != '0);
    o_instr    = '0;
    o_instr_pc = '0;
    if (count != '0) begin
      o_instr    = fifo_instr[rd_ptr];
      o_instr_pc = fifo_pc[rd_ptr];
    end
  end

  always_ff @(posedge I_clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= I_imem_data;
      fifo_pc[wr_ptr]    <= o_imem_addr;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (I_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // A request leaves IDLE only with room in the buffer, so at most one is
  // ever outstanding and the FIFO cannot overflow.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state       <= IDLE;
      o_imem_req  <= 1'b0;
      o_imem_addr <= '0;
      o_pc_adv    <= 1'b0;
    end else begin
      o_pc_adv <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!I_flush && (count < CW'(DEPTH))) begin
            o_imem_req  <= 1'b1;
            o_imem_addr <= I_pc;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (I_imem_ack) begin
            o_imem_req <= 1'b0;
            o_pc_adv   <= !I_flush;
            state      <= IDLE;
          end else if (I_flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (I_imem_ack) begin
            o_imem_req <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          o_imem_req <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios with a scoreboard of expected
// {pc, instr} pairs popped by a monitor whenever decode accepts the head.
module tb_fetch_unit;

  logic        I_clk;
  logic        I_rst_n;
  logic [15:0] I_pc;
  logic        I_flush;
  logic        o_imem_req;
  logic [15:0] o_imem_addr;
  logic        I_imem_ack;
  logic [15:0] I_imem_data;
  logic        o_pc_adv;
  logic        o_valid;
  logic [15:0] o_instr;
  logic [15:0] o_instr_pc;
  logic        I_ready;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [31:0] sb [$];
  int          req_cyc [$];
  logic [15:0] req_addr [$];
  int          adv_cyc [$];
  int          len_log [$];
  int          run_len = 0;
  logic [15:0] run_addr = '0;
  int          stable_err = 0;
  logic        prev_req = 1'b0;

  int          mem_delay = 1;
  int          mem_cnt = 0;
  logic        bad_en = 1'b0;
  logic [15:0] pc_base = '0;
  int          adv_total = 0;
  int          adv_mark = 0;

  fetch_unit #(.DEPTH(2)) dut (
    .I_clk       (I_clk),
    .I_rst_n     (I_rst_n),
    .I_pc        (I_pc),
    .I_flush     (I_flush),
    .o_imem_req  (o_imem_req),
    .o_imem_addr (o_imem_addr),
    .I_imem_ack  (I_imem_ack),
    .I_imem_data (I_imem_data),
    .o_pc_adv    (o_pc_adv),
    .o_valid     (o_valid),
    .o_instr     (o_instr),
    .o_instr_pc  (o_instr_pc),
    .I_ready     (I_ready)
  );

  initial begin
    I_clk = 1'b0;
    forever #5 I_clk = ~I_clk;
  end

  always @(posedge I_clk) cyc++;

  // PC unit: increments on o_pc_adv within the pulse cycle, redirect via pc_base.
  assign I_pc = pc_base + 16'(adv_total - adv_mark);

  always begin
    @(posedge I_clk);
    #2;
    if (I_rst_n && o_pc_adv) adv_total++;
  end

  // Memory: acks mem_delay cycles after the request first appears.
  always begin
    @(posedge I_clk);
    #2;
    if (!I_rst_n || !o_imem_req || I_imem_ack) begin
      I_imem_ack  = 1'b0;
      I_imem_data = '0;
      mem_cnt     = 0;
    end else if (mem_cnt == mem_delay) begin
      I_imem_ack  = 1'b1;
      I_imem_data = bad_en ? 16'hBEEF : (16'hA000 | o_imem_addr);
    end else begin
      mem_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int qi(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic logic [15:0] qa(input logic [15:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 16'hFFFF;
  endfunction

  // Monitor: request/adv logging and scoreboard pops on every accepted head.
  always @(negedge I_clk) begin
    logic [31:0] exp;
    if (I_rst_n) begin
      if (o_imem_req && !prev_req) begin
        req_cyc.push_back(cyc);
        req_addr.push_back(o_imem_addr);
        run_len  = 1;
        run_addr = o_imem_addr;
      end else if (o_imem_req) begin
        run_len++;
        if (o_imem_addr !== run_addr) stable_err++;
      end else if (prev_req) begin
        len_log.push_back(run_len);
      end
      if (o_pc_adv) adv_cyc.push_back(cyc);
      if (o_valid && I_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_unexpected: got pc %h instr %h expected none", o_instr_pc, o_instr);
        end else begin
          exp = sb.pop_front();
          check("pop_head", {o_instr_pc, o_instr}, exp);
        end
      end
    end
    prev_req = I_rst_n ? o_imem_req : 1'b0;
  end

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic set_pc(input logic [15:0] v);
    pc_base  = v;
    adv_mark = adv_total;
  endtask

  task automatic hold_reset();
    I_rst_n = 1'b0;
    I_flush = 1'b0;
    I_ready = 1'b0;
    mem_delay = 1;
    bad_en = 1'b0;
    sb.delete();
    tick();
    tick();
  endtask

  task automatic release_rst(output int c, output int rb, output int ab, output int lb);
    rb = req_cyc.size();
    ab = adv_cyc.size();
    lb = len_log.size();
    I_rst_n = 1'b1;
    c = cyc;
  endtask

  task automatic wait_reqs(input int n, input string name);
    for (int i = 0; i < 200 && req_cyc.size() < n; i++) tick();
    if (req_cyc.size() < n) begin
      tests++;
      fails++;
      $display("FAIL %s: got %0d requests expected %0d", name, req_cyc.size(), n);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    I_ready = 1'b0;
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s: got %0d pending expected 0", name, sb.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, rb, ab, lb, p, se;
    I_rst_n = 1'b0;
    I_flush = 1'b0;
    I_ready = 1'b0;
    tick();
    tick();
    check("rst_req", 32'(o_imem_req), 32'd0);
    check("rst_addr", 32'(o_imem_addr), 32'd0);
    check("rst_adv", 32'(o_pc_adv), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_instr", 32'(o_instr), 32'd0);
    check("rst_instr_pc", 32'(o_instr_pc), 32'd0);

    // Zero-wait stream from pc 0.
    hold_reset();
    set_pc(16'h0000);
    I_ready = 1'b1;
    sb.push_back({16'h0000, 16'hA000});
    sb.push_back({16'h0001, 16'hA001});
    sb.push_back({16'h0002, 16'hA002});
    release_rst(c, rb, ab, lb);
    wait_reqs(rb + 3, "t1_reqs");
    drain("t1_drain");
    tick();
    check("t1_req0_cyc", 32'(qi(req_cyc, rb)), 32'(c + 1));
    check("t1_req0_addr", 32'(qa(req_addr, rb)), 32'h0000);
    check("t1_req1_cyc", 32'(qi(req_cyc, rb + 1)), 32'(c + 4));
    check("t1_req1_addr", 32'(qa(req_addr, rb + 1)), 32'h0001);
    check("t1_req2_cyc", 32'(qi(req_cyc, rb + 2)), 32'(c + 7));
    check("t1_req2_addr", 32'(qa(req_addr, rb + 2)), 32'h0002);
    check("t1_adv0_cyc", 32'(qi(adv_cyc, ab)), 32'(c + 3));
    check("t1_adv1_cyc", 32'(qi(adv_cyc, ab + 1)), 32'(c + 6));
    check("t1_adv2_cyc", 32'(qi(adv_cyc, ab + 2)), 32'(c + 9));
    check("t1_req_len", 32'(qi(len_log, lb)), 32'd2);

    // Full buffer stalls requests; first pop reopens fetch.
    hold_reset();
    set_pc(16'h0010);
    sb.push_back({16'h0010, 16'hA010});
    sb.push_back({16'h0011, 16'hA011});
    sb.push_back({16'h0012, 16'hA012});
    release_rst(c, rb, ab, lb);
    repeat (12) tick();
    check("t2_req_count_full", 32'(req_cyc.size() - rb), 32'd2);
    check("t2_req_low", 32'(o_imem_req), 32'd0);
    check("t2_valid_full", 32'(o_valid), 32'd1);
    check("t2_head_pc", 32'(o_instr_pc), 32'h0010);
    check("t2_adv_count", 32'(adv_cyc.size() - ab), 32'd2);
    I_ready = 1'b1;
    p = cyc;
    wait_reqs(rb + 3, "t2_reqs");
    check("t2_req2_cyc", 32'(qi(req_cyc, rb + 2)), 32'(p + 2));
    check("t2_req2_addr", 32'(qa(req_addr, rb + 2)), 32'h0012);
    drain("t2_drain");

    // Four-cycle ack delay.
    hold_reset();
    set_pc(16'h0020);
    mem_delay = 4;
    I_ready = 1'b1;
    se = stable_err;
    sb.push_back({16'h0020, 16'hA020});
    release_rst(c, rb, ab, lb);
    for (int i = 0; i < 50 && len_log.size() <= lb; i++) tick();
    check("t3_req_len", 32'(qi(len_log, lb)), 32'd5);
    check("t3_addr_stable", 32'(stable_err - se), 32'd0);
    check("t3_req_addr", 32'(qa(req_addr, rb)), 32'h0020);
    check("t3_adv_cyc", 32'(qi(adv_cyc, ab)), 32'(c + 6));
    drain("t3_drain");
    check("t3_adv_count", 32'(adv_cyc.size() - ab), 32'd1);

    // Flush mid-WAIT, late ack carries 0xBEEF into DRAIN.
    hold_reset();
    set_pc(16'h0030);
    mem_delay = 4;
    bad_en = 1'b1;
    I_ready = 1'b1;
    sb.push_back({16'h0040, 16'hA040});
    release_rst(c, rb, ab, lb);
    tick();
    tick();
    I_flush = 1'b1;
    set_pc(16'h0040);
    tick();
    I_flush = 1'b0;
    check("t4_drain_req_held", 32'(o_imem_req), 32'd1);
    check("t4_drain_addr_held", 32'(o_imem_addr), 32'h0030);
    tick();
    tick();
    tick();
    bad_en = 1'b0;
    check("t4_req_dropped", 32'(o_imem_req), 32'd0);
    check("t4_valid", 32'(o_valid), 32'd0);
    check("t4_no_adv", 32'(adv_cyc.size() - ab), 32'd0);
    wait_reqs(rb + 2, "t4_reqs");
    check("t4_req1_cyc", 32'(qi(req_cyc, rb + 1)), 32'(c + 7));
    check("t4_req1_addr", 32'(qa(req_addr, rb + 1)), 32'h0040);
    check("t4_req0_len", 32'(qi(len_log, lb)), 32'd5);
    drain("t4_drain");

    // Flush coincident with ack.
    hold_reset();
    set_pc(16'h0050);
    I_ready = 1'b1;
    sb.push_back({16'h0060, 16'hA060});
    release_rst(c, rb, ab, lb);
    tick();
    tick();
    I_flush = 1'b1;
    set_pc(16'h0060);
    tick();
    I_flush = 1'b0;
    check("t5_valid", 32'(o_valid), 32'd0);
    check("t5_adv", 32'(o_pc_adv), 32'd0);
    check("t5_req", 32'(o_imem_req), 32'd0);
    wait_reqs(rb + 2, "t5_reqs");
    check("t5_req1_cyc", 32'(qi(req_cyc, rb + 1)), 32'(c + 4));
    check("t5_req1_addr", 32'(qa(req_addr, rb + 1)), 32'h0060);
    drain("t5_drain");
    check("t5_first_adv_cyc", 32'(qi(adv_cyc, ab)), 32'(c + 6));

    // Flush coincident with a pop on a full buffer.
    hold_reset();
    set_pc(16'h0070);
    sb.push_back({16'h0070, 16'hA070});
    release_rst(c, rb, ab, lb);
    repeat (10) tick();
    check("t6_valid_full", 32'(o_valid), 32'd1);
    check("t6_req_count", 32'(req_cyc.size() - rb), 32'd2);
    I_ready = 1'b1;
    I_flush = 1'b1;
    tick();
    I_flush = 1'b0;
    I_ready = 1'b0;
    check("t6_valid_empty", 32'(o_valid), 32'd0);
    check("t6_instr_zero", 32'(o_instr), 32'd0);
    check("t6_instr_pc_zero", 32'(o_instr_pc), 32'd0);
    check("t6_sb_popped", 32'(sb.size()), 32'd0);
    check("t6_adv_count", 32'(adv_cyc.size() - ab), 32'd2);
    check("t6_adv_now", 32'(o_pc_adv), 32'd0);

    // Asynchronous reset in WAIT.
    hold_reset();
    set_pc(16'h0080);
    mem_delay = 8;
    I_ready = 1'b1;
    release_rst(c, rb, ab, lb);
    tick();
    tick();
    tick();
    check("t7_pre_req", 32'(o_imem_req), 32'd1);
    check("t7_pre_addr", 32'(o_imem_addr), 32'h0080);
    #2;
    I_rst_n = 1'b0;
    #1;
    check("t7_arst_req", 32'(o_imem_req), 32'd0);
    check("t7_arst_addr", 32'(o_imem_addr), 32'd0);
    check("t7_arst_adv", 32'(o_pc_adv), 32'd0);
    check("t7_arst_valid", 32'(o_valid), 32'd0);
    check("t7_arst_instr", 32'(o_instr), 32'd0);
    check("t7_arst_instr_pc", 32'(o_instr_pc), 32'd0);
    mem_delay = 1;
    set_pc(16'h0084);
    sb.delete();
    sb.push_back({16'h0084, 16'hA084});
    tick();
    tick();
    release_rst(c, rb, ab, lb);
    wait_reqs(rb + 1, "t7_reqs");
    check("t7_req_cyc", 32'(qi(req_cyc, rb)), 32'(c + 1));
    check("t7_req_addr", 32'(qa(req_addr, rb)), 32'h0084);
    drain("t7_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 2: number of instruction buffer entries; legal values are 2 and 4.
REQ-002 I_clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 I_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 I_pc  in  16  current program counter from the PC unit.
REQ-005 I_flush  in  1  synchronous redirect; discard all fetched and in-flight instructions.
REQ-006 o_imem_req  out  1  instruction memory request.
REQ-007 o_imem_addr  out  16  word address of the request.
REQ-008 I_imem_ack  in  1  memory response strobe; I_imem_data is valid in the ack cycle.
REQ-009 I_imem_data  in  16  instruction word returned by memory.
REQ-010 o_pc_adv  out  1  one-cycle pulse that tells the PC unit to increment.
REQ-011 o_valid  out  1  buffer head holds an instruction for decode.
REQ-012 o_instr  out  16  head instruction word.
REQ-013 o_instr_pc  out  16  address of the head instruction.
REQ-014 I_ready  in  1  decode accepts the head instruction this cycle.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and DRAIN.
REQ-016 IDLE, with I_flush=0 and count<DEPTH: on the next edge, set o_imem_req=1 and o_imem_addr=I_pc, then go to WAIT.
REQ-017 IDLE, with count==DEPTH or I_flush=1: issue no request and stay in IDLE.
REQ-018 WAIT: hold o_imem_req=1 and o_imem_addr stable until I_imem_ack=1; the number of wait cycles is unbounded.
REQ-019 WAIT with ack and no flush, on the next edge:
- push {o_imem_addr, I_imem_data} into the buffer;
- drive o_imem_req=0;
- drive o_pc_adv=1 for exactly one cycle;
- go to IDLE.
REQ-020 o_pc_adv SHALL be 0 in all other cycles.
REQ-021 Throughput with zero-wait memory SHALL be one instruction per 3 cycles (IDLE -> WAIT -> IDLE/adv -> next request).
REQ-022 The buffer SHALL be a FIFO with read and write pointers that wrap modulo DEPTH, and a count of width clog2(DEPTH)+1.
REQ-023 o_valid SHALL equal (count!=0).
REQ-024 o_instr and o_instr_pc SHALL show the head entry when o_valid=1 and 16'h0000 otherwise.
REQ-025 Pop occurs when o_valid && I_ready; a pop and a push in the same cycle SHALL leave count unchanged and keep FIFO order.
REQ-026 Overflow SHALL be impossible: a request is issued only when count<DEPTH, and at most one request is ever outstanding.
REQ-027 I_flush=1 on any edge SHALL:
- set count=0 and both pointers to 0;
- take precedence over any pop or push in that cycle;
- force o_pc_adv=0 in the next cycle.
REQ-028 Flush in WAIT without ack: go to DRAIN and keep o_imem_req and o_imem_addr held.
REQ-029 DRAIN: on ack, drop the data, drive o_imem_req=0 and go to IDLE with no o_pc_adv; a flush while in DRAIN keeps the state in DRAIN.
REQ-030 Flush in WAIT in the same cycle as ack: drop the data, go to IDLE, no o_pc_adv pulse.
REQ-031 The fetch unit SHALL NOT redirect the PC; the redirect is driven externally while I_flush is asserted.
REQ-032 I_imem_ack in IDLE SHALL be ignored.

Reset
REQ-033 While I_rst_n=0, the block SHALL immediately hold: state=IDLE, o_imem_req=0, o_imem_addr=0, o_pc_adv=0, count=0, pointers=0, o_valid=0, o_instr=0, o_instr_pc=0.
REQ-034 The first request SHALL issue on the first rising edge after reset deassertion, with o_imem_addr=I_pc.
REQ-035 Reset in WAIT or DRAIN SHALL abandon the outstanding request; memory is reset by the same I_rst_n.

Verification
REQ-036 Release reset with I_pc=0, zero-wait ack, I_ready=1 -> requests to 0x0000, 0x0001, 0x0002 one every 3 cycles; o_instr_pc follows in order; one o_pc_adv per instruction.
REQ-037 I_ready=0, DEPTH=2, two instructions fetched -> count=2, o_imem_req stays 0; raise I_ready -> the next request issues the cycle after the first pop.
REQ-038 Ack delayed 4 cycles -> o_imem_req and o_imem_addr held stable for 5 cycles; single o_pc_adv pulse.
REQ-039 Flush 2 cycles into WAIT, ack 3 cycles later -> DRAIN, data 0xBEEF never appears on o_instr, no o_pc_adv, o_valid=0, next request uses the redirected I_pc=0x0040.
REQ-040 Flush coincident with ack, and flush coincident with a pop on a full buffer -> buffer empty next cycle, no o_pc_adv.
REQ-041 Assert I_rst_n=0 mid-WAIT, asynchronously to I_clk -> all outputs zero immediately; after release, a fresh request issues at I_pc.
